seven_seg_reader: RTL and testbench
===================================

SEVEN_SEG_READER -- requirements
Module: seven_seg_reader

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, number of consecutive matching samples required before a digit is accepted; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 seg  input  7  segment cathodes {g,f,e,d,c,b,a}, active-low, asynchronous to clk.
REQ-005 anode  input  8  digit anodes, active-low; bit i selects digit i; asynchronous to clk.
REQ-006 DP  input  1  decimal point cathode, active-low, asynchronous to clk.
REQ-007 clear  input  1  synchronous; when high, clears all digit-valid flags.
REQ-008 rd_sel  input  3  read-port digit index.
REQ-009 rd_num  output  4  stored hex value of digit rd_sel; combinational from the register file.
REQ-010 rd_dp  output  1  stored decimal point of digit rd_sel, active-high.
REQ-011 rd_valid  output  1  digit rd_sel has been captured since the last reset or clear.
REQ-012 upd  output  1  one-cycle pulse on each accepted capture.
REQ-013 upd_idx  output  3  digit index of the most recent capture; held between captures.
REQ-014 decode_err  output  1  one-cycle pulse when a stable pattern does not decode.

Function
REQ-015 Input sync: {anode,seg,DP} SHALL pass through two flop stages, s1 then s2, before any use.
REQ-016 Stability counter cnt (8 bits) SHALL behave as follows each edge: if s1!=s2, cnt=0; else if cnt<STABLE_CYCLES, cnt=cnt+1; else cnt holds (saturates).
REQ-017 A capture event SHALL occur on the edge where cnt goes from STABLE_CYCLES-1 to STABLE_CYCLES, and s2.anode has exactly one bit low.
REQ-018 Capture occurs at most once per stable period; cnt saturation SHALL prevent any repeat capture until the inputs change.
REQ-019 Latency: for inputs stable from sampling edge k, capture results SHALL be visible after edge k+1+STABLE_CYCLES (edge k+5 at default).
REQ-020 anode all-high (blank) or more than one bit low SHALL produce neither a capture nor decode_err; cnt still counts.
REQ-021 Decode table, seg value to hex: 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9, 0001000=A, 0000011=b, 1000110=C, 0100001=d, 0000110=E, 0001110=F.
REQ-022 Valid capture: digit[idx] SHALL take the decoded value, dp[idx] SHALL take ~DP, valid[idx] SHALL be set, upd SHALL pulse, and upd_idx SHALL take idx.
REQ-023 Capture of a seg pattern not in the table: decode_err SHALL pulse; digit, dp, valid, upd and upd_idx SHALL be unchanged.
REQ-024 clear and capture on the same edge: all valid flags SHALL clear first, then the captured digit's flag SHALL set, so only that digit reads valid.
REQ-025 The read port SHALL have no latency; a capture is visible on rd_* in the cycle after its edge.

Reset
REQ-026 reset low SHALL immediately set s1, s2 and cnt to 0, all digit/dp/valid bits to 0, and upd, upd_idx and decode_err to 0.
REQ-027 Reset asserted mid-stability SHALL abort the pending capture; after release, a full stability period SHALL be required before any capture.
REQ-028 Reset release SHALL be synchronised to clk by the integrator; the block treats deassertion as synchronous.

Verification
REQ-029 Reset: assert reset with any inputs -> rd_valid=0, rd_num=0, upd=0 and decode_err=0 for all rd_sel.
REQ-030 Single digit: anode=11111011, seg=0100100, DP=0 held 10 cycles -> exactly one upd pulse, 5 edges after the first sampling edge, with upd_idx=2; rd_sel=2 gives rd_num=2, rd_dp=1, rd_valid=1; rd_valid=0 for all other digits.
REQ-031 Glitch rejection: a pattern held 3 cycles then changed -> no upd and no decode_err; the following pattern held 5 cycles is captured.
REQ-032 Errors and illegal anodes: seg=1111111 on anode=11111110 -> one decode_err pulse, valid[0] stays 0; anode=11111100 with a legal seg -> no upd and no decode_err.
REQ-033 Full sweep: all 8 digits x 16 values, each pattern held 8 cycles -> 128 upd pulses; readback of each digit equals the last value driven on it.
REQ-034 clear on the capture edge of digit 5, with digits 0..4 previously valid -> only rd_valid for digit 5 is 1 afterwards.

Source files
------------

// File: rtl/seven_seg_reader.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_reader
//  Description : Snoops a multiplexed, active-low 7-segment display bus and
//                rebuilds the eight displayed hex digits (plus decimal points)
//                in a register file with a zero-latency read port.
//                The bus is double-flopped.
//                A pattern must sit unchanged for STABLE_CYCLES samples before
//                it is accepted, which filters out anode/cathode switching.
//  Ports       : clk        - clock, rising edge
//                reset      - asynchronous active-low reset
//                seg[6:0]   - {g,f,e,d,c,b,a} cathodes, active-low
//                anode[7:0] - digit anodes, active-low, bit i = digit i
//                DP         - decimal point cathode, active-low
//                clear      - synchronous clear of all digit-valid flags
//                rd_sel     - read-port digit index
//                rd_num     - stored hex value of digit rd_sel
//                rd_dp      - stored decimal point of digit rd_sel (active-high)
//                rd_valid   - digit rd_sel captured since reset/clear
//                upd        - one-cycle pulse per accepted capture
//                upd_idx    - index of the most recent capture
//                decode_err - one-cycle pulse on a stable, undecodable pattern
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg,
    input  logic [7:0] anode,
    input  logic       DP,
    input  logic       clear,
    input  logic [2:0] rd_sel,
    output logic [3:0] rd_num,
    output logic       rd_dp,
    output logic       rd_valid,
    output logic       upd,
    output logic [2:0] upd_idx,
    output logic       decode_err
);

    localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

    // Bus snapshot layout: {anode[7:0], seg[6:0], DP}
    logic [15:0]      s1_q, s2_q;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0][3:0]  digit_q, digit_d;
    logic [7:0]       dp_q, dp_d;
    logic [7:0]       valid_q, valid_d;
    logic             upd_q, upd_d;
    logic [2:0]       upd_idx_q, upd_idx_d;
    logic             err_q, err_d;

    logic             same;
    logic             stable_edge;
    logic [7:0]       an_low;
    logic             onehot;
    logic [2:0]       idx;
    logic [4:0]       dec;        // {ok, value}
    logic             capture;

    // Returns {1'b1, value} for a legal glyph, 5'b0 otherwise.
    function automatic logic [4:0] decode7(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1000000: r = {1'b1, 4'h0};
            7'b1111001: r = {1'b1, 4'h1};
            7'b0100100: r = {1'b1, 4'h2};
            7'b0110000: r = {1'b1, 4'h3};
            7'b0011001: r = {1'b1, 4'h4};
            7'b0010010: r = {1'b1, 4'h5};
            7'b0000010: r = {1'b1, 4'h6};
            7'b1111000: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0010000: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b0000011: r = {1'b1, 4'hB};
            7'b1000110: r = {1'b1, 4'hC};
            7'b0100001: r = {1'b1, 4'hD};
            7'b0000110: r = {1'b1, 4'hE};
            7'b0001110: r = {1'b1, 4'hF};
            default:    r = 5'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        same  = (s1_q == s2_q);
        cnt_d = cnt_q;
        if (!same) begin
            cnt_d = 8'd0;
        end else if (cnt_q < STABLE_C) begin
            cnt_d = cnt_q + 8'd1;
        end
        // Fires only on the single edge the counter reaches STABLE_C; the
        // saturated counter then blocks repeats until the bus changes.
        stable_edge = same && (cnt_q == (STABLE_C - 8'd1));

        an_low = ~s2_q[15:8];
        onehot = (an_low != 8'd0) && ((an_low & (an_low - 8'd1)) == 8'd0);
        idx    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (an_low[i]) begin
                idx = 3'(i);
            end
        end

        dec     = decode7(s2_q[7:1]);
        capture = stable_edge && onehot;

        digit_d   = digit_q;
        dp_d      = dp_q;
        // Clear takes effect first so a same-edge capture still sets its flag.
        valid_d   = clear ? 8'd0 : valid_q;
        upd_d     = 1'b0;
        upd_idx_d = upd_idx_q;
        err_d     = 1'b0;

        if (capture) begin
            if (dec[4]) begin
                digit_d[idx] = dec[3:0];
                dp_d[idx]    = ~s2_q[0];
                valid_d[idx] = 1'b1;
                upd_d        = 1'b1;
                upd_idx_d    = idx;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q      <= 16'd0;
            s2_q      <= 16'd0;
            cnt_q     <= 8'd0;
            digit_q   <= '0;
            dp_q      <= 8'd0;
            valid_q   <= 8'd0;
            upd_q     <= 1'b0;
            upd_idx_q <= 3'd0;
            err_q     <= 1'b0;
        end else begin
            s1_q      <= {anode, seg, DP};
            s2_q      <= s1_q;
            cnt_q     <= cnt_d;
            digit_q   <= digit_d;
            dp_q      <= dp_d;
            valid_q   <= valid_d;
            upd_q     <= upd_d;
            upd_idx_q <= upd_idx_d;
            err_q     <= err_d;
        end
    end

    assign rd_num     = digit_q[rd_sel];
    assign rd_dp      = dp_q[rd_sel];
    assign rd_valid   = valid_q[rd_sel];
    assign upd        = upd_q;
    assign upd_idx    = upd_idx_q;
    assign decode_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_seg_reader
//  Description : Scoreboard bench for seven_seg_reader. Stimulus pushes the
//                expected upd/decode_err event (kind, index, edge number) into
//                a queue; a negedge monitor pops and compares on every pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_reader;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] seg = 7'h7F;
    logic [7:0] anode = 8'h00;
    logic       DP = 1'b1;
    logic       clear = 1'b0;
    logic [2:0] rd_sel = 3'd0;
    logic [3:0] rd_num;
    logic       rd_dp, rd_valid, upd, decode_err;
    logic [2:0] upd_idx;

    seven_seg_reader #(.STABLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .seg(seg), .anode(anode), .DP(DP),
        .clear(clear), .rd_sel(rd_sel), .rd_num(rd_num), .rd_dp(rd_dp),
        .rd_valid(rd_valid), .upd(upd), .upd_idx(upd_idx),
        .decode_err(decode_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         err;
        logic [2:0] idx;
        longint     cyc;
    } exp_t;

    exp_t   q[$];
    longint cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    int     n_upd = 0;

    logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every pulse must match the head of the scoreboard queue.
    always @(negedge clk) begin
        if (reset && (upd || decode_err)) begin
            if (upd) n_upd++;
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: upd=%0b decode_err=%0b idx=%0d at edge %0d",
                         upd, decode_err, upd_idx, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("event_is_err", longint'(decode_err), longint'(e.err));
                check("event_edge", cyc, e.cyc);
                if (!e.err) check("upd_idx", longint'(upd_idx), longint'(e.idx));
            end
        end
    end

    // Drive one bus pattern for n cycles; kind 0=no event, 1=upd, 2=decode_err.
    // Called just after a negedge; capture is expected on edge cyc+2+S.
    task automatic hold(input logic [7:0] a, input logic [6:0] s, input logic d,
                        input int n, input int kind, input logic [2:0] i);
        exp_t e;
        anode = a; seg = s; DP = d;
        if (kind != 0) begin
            e.err = (kind == 2);
            e.idx = i;
            e.cyc = cyc + 2 + S;
            q.push_back(e);
        end
        repeat (n) @(negedge clk);
    endtask

    task automatic read(input logic [2:0] sel);
        rd_sel = sel;
        #1;
    endtask

    initial begin
        int base;
        // Reset with arbitrary inputs
        anode = 8'hA5; seg = 7'h12; DP = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 8; d++) begin
            read(3'(d));
            check("reset_valid", longint'(rd_valid), 0);
            check("reset_num", longint'(rd_num), 0);
        end
        check("reset_upd", longint'(upd), 0);
        check("reset_err", longint'(decode_err), 0);
        anode = 8'hFF; seg = 7'h7F; DP = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Single digit 2, DP on
        hold(8'b11111011, 7'b0100100, 1'b0, 10, 1, 3'd2);
        hold(8'hFF, 7'h7F, 1'b1, 3, 0, 3'd0);
        for (int d = 0; d < 8; d++) begin
            read(3'(d));
            check("single_valid", longint'(rd_valid), (d == 2) ? 1 : 0);
        end
        read(3'd2);
        check("single_num", longint'(rd_num), 2);
        check("single_dp", longint'(rd_dp), 1);

        // Glitch rejection: 3 cycles of digit 4, then 5 cycles of digit 6
        hold(8'b11101111, seg_tab[7], 1'b1, 3, 0, 3'd0);
        hold(8'b10111111, seg_tab[13], 1'b1, 5, 1, 3'd6);
        hold(8'hFF, 7'h7F, 1'b1, 3, 0, 3'd0);
        read(3'd4);
        check("glitch_valid4", longint'(rd_valid), 0);
        read(3'd6);
        check("glitch_num6", longint'(rd_num), 13);
        check("glitch_dp6", longint'(rd_dp), 0);

        // Undecodable glyph, then two anodes low
        hold(8'b11111110, 7'b1111111, 1'b0, 8, 2, 3'd0);
        hold(8'b11111100, seg_tab[3], 1'b0, 8, 0, 3'd0);
        hold(8'hFF, 7'h7F, 1'b1, 3, 0, 3'd0);
        read(3'd0);
        check("err_valid0", longint'(rd_valid), 0);
        read(3'd1);
        check("dual_anode_valid1", longint'(rd_valid), 0);
        check("upd_idx_hold", longint'(upd_idx), 6);

        // Reset mid-stability aborts, then a full period is needed
        anode = 8'b11111101; seg = seg_tab[7]; DP = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        read(3'd2);
        check("midreset_valid2", longint'(rd_valid), 0);
        reset = 1'b1;
        hold(8'b11111101, seg_tab[7], 1'b1, 8, 1, 3'd1);
        hold(8'hFF, 7'h7F, 1'b1, 3, 0, 3'd0);
        read(3'd1);
        check("postreset_num1", longint'(rd_num), 7);
        check("postreset_valid1", longint'(rd_valid), 1);

        // Full sweep: per digit d, values (v+d)%16, last = (15+d)%16
        base = n_upd;
        for (int d = 0; d < 8; d++) begin
            for (int v = 0; v < 16; v++) begin
                int val;
                val = (v + d) % 16;
                hold(~(8'd1 << d), seg_tab[val], val[0], 8, 1, 3'(d));
            end
        end
        hold(8'hFF, 7'h7F, 1'b1, 3, 0, 3'd0);
        check("sweep_upd_count", longint'(n_upd - base), 128);
        for (int d = 0; d < 8; d++) begin
            int last;
            last = (15 + d) % 16;
            read(3'(d));
            check("sweep_num", longint'(rd_num), longint'(last));
            check("sweep_dp", longint'(rd_dp), longint'(~last[0] & 1));
            check("sweep_valid", longint'(rd_valid), 1);
        end

        // Clear on the capture edge of digit 5
        anode = 8'b11011111; seg = seg_tab[9]; DP = 1'b1;
        begin
            exp_t e;
            e.err = 1'b0; e.idx = 3'd5; e.cyc = cyc + 2 + S;
            q.push_back(e);
        end
        repeat (1 + S) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        hold(8'hFF, 7'h7F, 1'b1, 3, 0, 3'd0);
        for (int d = 0; d < 8; d++) begin
            read(3'(d));
            check("clear_valid", longint'(rd_valid), (d == 5) ? 1 : 0);
        end
        read(3'd5);
        check("clear_num5", longint'(rd_num), 9);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", longint'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
